// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with a pending-write scoreboard and a registered debug read port.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data and busy status to the read ports.
module regfile_mp_sb #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NRP      = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned AW       = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRP*AW-1:0]   rs_addr,
  output logic [NRP*XLEN-1:0] rs_data,
  output logic [NRP-1:0]      rs_busy,
  input  logic                we,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_addr,
  output logic [NREGS-1:0]    busy_vec,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [XLEN-1:0]  dbg_data_q, dbg_data_d;
  logic             wr_en, iss_en;

  assign wr_en  = we && !((ZERO_REG != 0) && (wr_addr == '0));
  assign iss_en = iss_valid && !((ZERO_REG != 0) && (iss_addr == '0));

  always_comb begin
    regs_d     = regs_q;
    busy_d     = busy_q;
    // Debug samples the pre-write array.
    dbg_data_d = ((ZERO_REG != 0) && (dbg_addr == '0)) ? '0 : regs_q[dbg_addr];
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_d[i] = '0;
      end
      busy_d     = '0;
      dbg_data_d = '0;
    end else begin
      if (wr_en) begin
        regs_d[wr_addr] = wr_data;
      end
      if (we) begin
        busy_d[wr_addr] = 1'b0;
      end
      // Applied after the clear so a new producer supersedes the retiring one.
      if (iss_en) begin
        busy_d[iss_addr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    regs_q     <= regs_d;
    busy_q     <= busy_d;
    dbg_data_q <= dbg_data_d;
  end

  assign busy_vec = busy_q;
  assign dbg_data = dbg_data_q;

  for (genvar k = 0; k < NRP; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic            zero;
    logic [XLEN-1:0] data;
    logic            busy;

    assign addr = rs_addr[k*AW +: AW];
    assign zero = (ZERO_REG != 0) && (addr == '0);

`ifdef REGFILE_BYPASS_EN
    logic hit;
    // Writes are discarded under reset, so nothing is forwarded then.
    assign hit  = we && !reset && (addr == wr_addr) && !zero;
    assign data = zero ? '0 : (hit ? wr_data : regs_q[addr]);
    assign busy = zero ? 1'b0 : (hit ? (iss_valid && (iss_addr == wr_addr)) : busy_q[addr]);
`else
    assign data = zero ? '0 : regs_q[addr];
    assign busy = zero ? 1'b0 : busy_q[addr];
`endif

    assign rs_data[k*XLEN +: XLEN] = data;
    assign rs_busy[k]              = busy;
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb (NRP=3): directed plan steps then random traffic
// compared against an array-based reference model.
module tb_regfile_mp_sb;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int NRP   = 3;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                reset;
  logic [NRP*AW-1:0]   rs_addr;
  logic [NRP*XLEN-1:0] rs_data;
  logic [NRP-1:0]      rs_busy;
  logic                we;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                iss_valid;
  logic [AW-1:0]       iss_addr;
  logic [NREGS-1:0]    busy_vec;
  logic [AW-1:0]       dbg_addr;
  logic [XLEN-1:0]     dbg_data;

  int total = 0;
  int bad   = 0;

  // Reference model: architectural contents, pending flags, debug register.
  logic [XLEN-1:0] m_mem  [NREGS];
  bit              m_busy [NREGS];
  logic [XLEN-1:0] m_dbg;

  regfile_mp_sb #(
    .XLEN    (XLEN),
    .NREGS   (NREGS),
    .NRP     (NRP),
    .ZERO_REG(1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rs_addr  (rs_addr),
    .rs_data  (rs_data),
    .rs_busy  (rs_busy),
    .we       (we),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_valid(iss_valid),
    .iss_addr (iss_addr),
    .busy_vec (busy_vec),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] port_data(input int k);
    return rs_data[k*XLEN +: XLEN];
  endfunction

  function automatic logic [AW-1:0] port_addr(input int k);
    return rs_addr[k*AW +: AW];
  endfunction

  task automatic set_rs(input int a0, input int a1, input int a2);
    rs_addr = {a2[AW-1:0], a1[AW-1:0], a0[AW-1:0]};
  endtask

  task automatic check_comb();
    logic [NREGS-1:0] exp_vec;
    for (int i = 0; i < NREGS; i++) exp_vec[i] = m_busy[i];
    chk("busy_vec", XLEN'(busy_vec), XLEN'(exp_vec));
    for (int k = 0; k < NRP; k++) begin
      int a;
      logic [XLEN-1:0] ed;
      logic eb;
      a  = int'(port_addr(k));
      ed = (a == 0) ? '0 : m_mem[a];
      eb = (a == 0) ? 1'b0 : m_busy[a];
`ifdef REGFILE_BYPASS_EN
      if (we && !reset && a != 0 && a == int'(wr_addr)) begin
        ed = wr_data;
        eb = iss_valid && (iss_addr == wr_addr);
      end
`endif
      chk($sformatf("rs_data[%0d]", k), port_data(k), ed);
      chk($sformatf("rs_busy[%0d]", k), XLEN'(rs_busy[k]), XLEN'(eb));
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
      m_dbg = '0;
    end else begin
      m_dbg = (dbg_addr == 0) ? '0 : m_mem[dbg_addr];
      if (we && wr_addr != 0) m_mem[wr_addr] = wr_data;
      if (we) m_busy[wr_addr] = 1'b0;
      if (iss_valid && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    end
  endtask

  // Check outputs for the current inputs, clock once, then check the debug register.
  task automatic cycle();
    #2;
    check_comb();
    @(posedge clk);
    model_edge();
    #1;
    chk("dbg_data", dbg_data, m_dbg);
  endtask

  task automatic idle();
    we = 0; iss_valid = 0; reset = 0;
  endtask

  task automatic wr(input int a, input logic [XLEN-1:0] d);
    we = 1; wr_addr = a[AW-1:0]; wr_data = d;
  endtask

  initial begin
    reset = 1; we = 0; wr_addr = '0; wr_data = '0; iss_valid = 0; iss_addr = '0;
    dbg_addr = '0; rs_addr = '0;
    @(posedge clk);
    model_edge();
    #1;
    reset = 0;
    cycle();

    // Reset wins over a same-edge write and issue.
    wr(5, 64'hDEAD); cycle();
    reset = 1; wr(5, 64'hBEEF); iss_valid = 1; iss_addr = 5; cycle();
    idle(); set_rs(5, 5, 5); dbg_addr = 5;
    #2;
    chk("reset_r5", port_data(0), 64'h0);
    chk("reset_busy_vec", XLEN'(busy_vec), 64'h0);
    chk("reset_dbg", dbg_data, 64'h0);
    cycle();

    // Zero register ignores writes and issues.
    wr(0, 64'h1234); iss_valid = 1; iss_addr = 0; set_rs(0, 0, 0); cycle();
    idle();
    #2;
    chk("zero_rd", port_data(1), 64'h0);
    chk("zero_busy0", XLEN'(busy_vec[0]), 64'h0);
    chk("zero_rs_busy", XLEN'(rs_busy), 64'h0);
    cycle();

    // Three ports with aliasing.
    wr(7, 64'h77); cycle();
    wr(9, 64'h99); cycle();
    idle(); set_rs(7, 9, 7);
    #2;
    chk("alias_p0", port_data(0), 64'h77);
    chk("alias_p1", port_data(1), 64'h99);
    chk("alias_p2", port_data(2), 64'h77);
    cycle();

    // Scoreboard: set wins over clear on the same register.
    iss_valid = 1; iss_addr = 4; cycle();
    wr(4, 64'h44); iss_valid = 1; iss_addr = 4; cycle();
    idle();
    #2;
    chk("setwins_busy4", XLEN'(busy_vec[4]), 64'h1);
    wr(4, 64'h45); cycle();
    idle();
    #2;
    chk("clear_busy4", XLEN'(busy_vec[4]), 64'h0);

    // Bypass behaviour of a same-cycle write.
    wr(3, 64'h10); cycle();
    set_rs(3, 0, 0); wr(3, 64'h20);
    #2;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_data", port_data(0), 64'h20);
    chk("bypass_busy", XLEN'(rs_busy[0]), 64'h0);
`else
    chk("nobypass_data", port_data(0), 64'h10);
`endif
    cycle();
    idle();
    #2;
    chk("after_write_data", port_data(0), 64'h20);

    // Debug port latency.
    wr(12, 64'h55); cycle();
    dbg_addr = 12; wr(12, 64'hABC); cycle();
    chk("dbg_old", dbg_data, 64'h55);
    idle(); cycle();
    chk("dbg_new", dbg_data, 64'hABC);

    // Random traffic on a small address window to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(0, 49) == 0);
      we        = $urandom_range(0, 1);
      wr_addr   = AW'($urandom_range(0, 11));
      wr_data   = {$urandom, $urandom};
      iss_valid = $urandom_range(0, 1);
      iss_addr  = AW'($urandom_range(0, 11));
      dbg_addr  = AW'($urandom_range(0, 11));
      set_rs($urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 11));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
